// File: rtl/reciprocal_arbiter_if.sv
// Bundle of client-side and reciprocal-unit-side signals for reciprocal_arbiter.
// The arbiter takes the master modport; clients and the unit sit on the slave side.
interface reciprocal_arbiter_if #(
   parameter int N_CLI = 4
);
   localparam int GW = (N_CLI > 1) ? $clog2(N_CLI) : 1;

   logic [N_CLI-1:0]   cli_req;
   logic [8*N_CLI-1:0] cli_A;
   logic [4*N_CLI-1:0] cli_n_iter;
   logic [N_CLI-1:0]   cli_done;
   logic [15:0]        cli_P;
   logic               cli_err;
   logic               busy;
   logic [GW-1:0]      grant_id;
   logic               rcp_req;
   logic [7:0]         rcp_A;
   logic [3:0]         rcp_n_iter;
   logic [15:0]        rcp_P;
   logic               rcp_ack;

   modport master (
      input  cli_req, cli_A, cli_n_iter, rcp_P, rcp_ack,
      output cli_done, cli_P, cli_err, busy, grant_id, rcp_req, rcp_A, rcp_n_iter
   );

   modport slave (
      output cli_req, cli_A, cli_n_iter, rcp_P, rcp_ack,
      input  cli_done, cli_P, cli_err, busy, grant_id, rcp_req, rcp_A, rcp_n_iter
   );
endinterface

// File: rtl/reciprocal_arbiter.sv
// Round-robin arbiter sharing one reciprocal unit among N_CLI clients, with a
// four-phase req/ack sequencer, zero-iteration shortcut and an ack watchdog.
module reciprocal_arbiter #(
   parameter int N_CLI   = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic                 clock,
   input  logic                 rst,
   reciprocal_arbiter_if.master bus
);
   localparam int GW = (N_CLI > 1) ? $clog2(N_CLI) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_RELEASE = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_ZDONE   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic          rcp_req_q, rcp_req_d;
   logic [7:0]    a_q, a_d;
   logic [3:0]    n_q, n_d;
   logic [15:0]   res_q, res_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   logic          found;
   logic [GW-1:0] sel;
   int            idx;
   logic [7:0]    a_sel;
   logic [3:0]    n_sel;

   // First requesting client at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int i = 0; i < N_CLI; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_CLI) idx = idx - N_CLI;
         if (!found && bus.cli_req[GW'(idx)]) begin
            found = 1'b1;
            sel   = GW'(idx);
         end
      end
   end

   always_comb begin
      a_sel = '0;
      n_sel = '0;
      for (int i = 0; i < N_CLI; i++) begin
         if (sel == GW'(i)) begin
            a_sel = bus.cli_A[8*i +: 8];
            n_sel = bus.cli_n_iter[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      rcp_req_d = rcp_req_q;
      a_d       = a_q;
      n_d       = n_q;
      res_d     = res_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            // A still-high ack left over from before reset blocks new grants.
            if (found && !bus.rcp_ack) begin
               grant_d = sel;
               a_d     = a_sel;
               n_d     = n_sel;
               res_d   = '0;
               if (n_sel == 4'd0) begin
                  state_d = S_ZDONE;
               end else begin
                  rcp_req_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (bus.rcp_ack) begin
               res_d     = bus.rcp_P;
               rcp_req_d = 1'b0;
               state_d   = S_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               res_d     = '0;
               err_d     = 1'b1;
               rcp_req_d = 1'b0;
               state_d   = S_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            if (!bus.rcp_ack) state_d = S_DONE;
         end
         S_DONE, S_ZDONE: begin
            ptr_d   = (grant_q == GW'(N_CLI - 1)) ? '0 : grant_q + 1'b1;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         rcp_req_q <= 1'b0;
         a_q       <= '0;
         n_q       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         rcp_req_q <= rcp_req_d;
         a_q       <= a_d;
         n_q       <= n_d;
         res_q     <= res_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Result and error are gated so they read zero outside the done cycle.
   always_comb begin
      bus.cli_done = '0;
      bus.cli_P    = '0;
      bus.cli_err  = 1'b0;
      if (state_q == S_DONE || state_q == S_ZDONE) begin
         bus.cli_done[grant_q] = 1'b1;
         bus.cli_P             = (state_q == S_ZDONE) ? 16'h0000 : res_q;
         bus.cli_err           = (state_q == S_ZDONE) | err_q;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.grant_id   = grant_q;
   assign bus.rcp_req    = rcp_req_q;
   assign bus.rcp_A      = a_q;
   assign bus.rcp_n_iter = n_q;
endmodule

// File: tb/tb_reciprocal_arbiter.sv
// Scoreboard bench for reciprocal_arbiter: a behavioural client/unit model predicts
// the round-robin serving order and results; a monitor checks every done strobe.
`timescale 1ns/1ps
module tb_reciprocal_arbiter;
   localparam int N = 4;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] p;
      logic        err;
   } exp_t;

   logic clock = 1'b0;
   logic rst;
   always #5 clock = ~clock;

   reciprocal_arbiter_if #(.N_CLI(N)) if1 ();
   reciprocal_arbiter_if #(.N_CLI(N)) if2 ();

   reciprocal_arbiter #(.N_CLI(N), .TIMEOUT(64)) dut (
      .clock(clock), .rst(rst), .bus(if1.master));
   reciprocal_arbiter #(.N_CLI(N), .TIMEOUT(16)) dut_to (
      .clock(clock), .rst(rst), .bus(if2.master));

   exp_t        sb[$];
   int          n_pass = 0;
   int          n_chk  = 0;
   int          pend_id[N];
   int          served_id[N];
   logic [N-1:0] hold_mask;
   logic [7:0]  opA[N];
   logic [3:0]  opN[N];
   logic        ack_m, ack_force;
   logic [15:0] p_m;
   int          cyc = 0;
   int          drop_cyc = -10;
   int          done_cnt = 0;
   int          mptr = 0;
   int          u_st = 0;
   int          u_cnt = 0;
   logic        use_dir;
   int          dir_lat;
   logic [15:0] dir_P;
   logic        mon_prev = 1'b0;
   logic [7:0]  mon_hA;
   logic [3:0]  mon_hN;
   exp_t        mon_e;
   int          mon_id;
   logic [3:0]  bmask;
   int          base, rises, hi, tw;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if1.cli_req[i]          = hold_mask[i] | (pend_id[i] != served_id[i]);
         if1.cli_A[8*i +: 8]     = opA[i];
         if1.cli_n_iter[4*i +: 4] = opN[i];
      end
   end
   assign if1.rcp_ack = ack_m | ack_force;
   assign if1.rcp_P   = p_m;

   function automatic logic [15:0] unit_f(input logic [7:0] a, input logic [3:0] n);
      return {a ^ 8'h96, n, 4'(a[7:4] + n)};
   endfunction

   function automatic exp_t mk_exp(input int id, input logic [15:0] p, input logic err);
      exp_t e;
      e.id  = 2'(id);
      e.p   = p;
      e.err = err;
      return e;
   endfunction

   function automatic exp_t model(input int c);
      if (opN[c] == 4'd0 || opA[c] == 8'hFF) return mk_exp(c, 16'h0000, 1'b1);
      return mk_exp(c, unit_f(opA[c], opN[c]), 1'b0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic issue_batch(input logic [3:0] m);
      int c, last;
      last = mptr;
      for (int i = 0; i < N; i++) begin
         c = (mptr + i) % N;
         if (m[c]) begin
            sb.push_back(model(c));
            last = c;
         end
      end
      mptr = (last + 1) % N;
      for (int i = 0; i < N; i++) if (m[i]) pend_id[i]++;
   endtask

   task automatic wait_req(input logic lvl, input string name);
      int t;
      t = 0;
      while (if1.rcp_req !== lvl && t < 200) begin
         @(negedge clock);
         t++;
      end
      chk(name, 32'(if1.rcp_req), 32'(lvl));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb.size() != 0 || if1.cli_req != '0) && t < 3000) begin
         @(negedge clock);
         t++;
      end
      chk("drain", sb.size(), 0);
      @(negedge clock);
   endtask

   task automatic wait_dones(input int target);
      int t;
      t = 0;
      while (done_cnt < target && t < 2000) begin
         @(negedge clock);
         t++;
      end
      chk("done_count", done_cnt, target);
   endtask

   task automatic do_reset();
      @(negedge clock);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      mptr = 0;
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Reciprocal unit model: four-phase handshake, operand A=FF never answered.
   initial begin
      ack_m = 1'b0;
      p_m   = '0;
      forever begin
         @(negedge clock);
         if (rst) begin
            u_st  = 0;
            ack_m = 1'b0;
         end else begin
            case (u_st)
               0: if (if1.rcp_req) begin
                     if (if1.rcp_A == 8'hFF) u_st = 4;
                     else begin
                        u_cnt = use_dir ? dir_lat : int'($urandom_range(0, 6));
                        u_st  = 1;
                     end
                  end
               1: if (u_cnt == 0) begin
                     ack_m = 1'b1;
                     p_m   = use_dir ? dir_P : unit_f(if1.rcp_A, if1.rcp_n_iter);
                     u_st  = 2;
                  end else u_cnt--;
               2: if (!if1.rcp_req) begin
                     u_cnt = use_dir ? 0 : int'($urandom_range(0, 2));
                     if (u_cnt == 0) begin
                        ack_m = 1'b0;
                        drop_cyc = cyc;
                        u_st = 0;
                     end else u_st = 3;
                  end
               3: begin
                     u_cnt--;
                     if (u_cnt == 0) begin
                        ack_m = 1'b0;
                        drop_cyc = cyc;
                        u_st = 0;
                     end
                  end
               default: if (!if1.rcp_req) u_st = 0;
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (!rst) begin
            if (if1.cli_done != '0) begin
               mon_id = 0;
               for (int i = 0; i < N; i++) if (if1.cli_done[i]) mon_id = i;
               chk("done_onehot", $countones(if1.cli_done), 1);
               if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
               else begin
                  mon_e = sb.pop_front();
                  chk("grant_id", mon_id, 32'(mon_e.id));
                  chk("cli_P", 32'(if1.cli_P), 32'(mon_e.p));
                  chk("cli_err", 32'(if1.cli_err), 32'(mon_e.err));
                  if (!mon_e.err) chk("done_latency", cyc, drop_cyc + 1);
               end
               served_id[mon_id] = pend_id[mon_id];
               done_cnt++;
            end else begin
               chk("idle_P_err", 32'({if1.cli_P, if1.cli_err}), 0);
            end
            if (if1.rcp_req && mon_prev) begin
               chk("rcp_A_stable", 32'(if1.rcp_A), 32'(mon_hA));
               chk("rcp_n_stable", 32'(if1.rcp_n_iter), 32'(mon_hN));
            end else if (if1.rcp_req) begin
               mon_hA = if1.rcp_A;
               mon_hN = if1.rcp_n_iter;
            end
         end
         mon_prev = if1.rcp_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      hold_mask = '0;
      ack_force = 1'b0;
      use_dir = 1'b0;
      dir_lat = 0;
      dir_P = '0;
      for (int i = 0; i < N; i++) begin
         pend_id[i] = 0;
         served_id[i] = 0;
         opA[i] = '0;
         opN[i] = '0;
      end
      if2.cli_req = '0;
      if2.cli_A = '0;
      if2.cli_n_iter = '0;
      if2.rcp_ack = 1'b0;
      if2.rcp_P = '0;
      repeat (2) @(negedge clock);
      chk("rst_ctrl", 32'({if1.busy, if1.rcp_req, if1.cli_err, if1.grant_id}), 0);
      chk("rst_data", 32'({if1.rcp_A, if1.rcp_n_iter, if1.cli_P}), 0);
      chk("rst_done", 32'(if1.cli_done), 0);
      rst = 1'b0;
      @(negedge clock);

      // single client, operands frozen while the unit works
      use_dir = 1'b1;
      dir_lat = 20;
      dir_P = 16'h0123;
      opA[0] = 8'hE1;
      opN[0] = 4'd8;
      sb.push_back(mk_exp(0, 16'h0123, 1'b0));
      pend_id[0]++;
      mptr = 1;
      wait_req(1'b1, "grant_single");
      @(negedge clock);
      chk("rcp_A_single", 32'(if1.rcp_A), 32'h E1);
      chk("rcp_n_single", 32'(if1.rcp_n_iter), 8);
      opA[0] = 8'h3C;
      opN[0] = 4'd2;
      repeat (10) @(negedge clock);
      chk("rcp_A_frozen", 32'(if1.rcp_A), 32'hE1);
      chk("rcp_n_frozen", 32'(if1.rcp_n_iter), 8);
      wait_idle();
      use_dir = 1'b0;

      // continuous requests from all clients
      do_reset();
      for (int i = 0; i < N; i++) begin
         opA[i] = 8'(8'h10 + i);
         opN[i] = 4'(i + 1);
      end
      base = done_cnt;
      for (int k = 0; k < 5; k++) sb.push_back(model(k % N));
      hold_mask = 4'hF;
      wait_dones(base + 5);
      hold_mask = '0;
      mptr = 1;
      wait_idle();

      // only clients 2 and 3, from ptr 0
      do_reset();
      base = done_cnt;
      sb.push_back(model(2));
      sb.push_back(model(3));
      sb.push_back(model(2));
      hold_mask = 4'b1100;
      wait_dones(base + 3);
      hold_mask = '0;
      mptr = 3;
      wait_idle();

      // zero iterations: done next cycle, unit never requested
      opA[1] = 8'h77;
      opN[1] = 4'd0;
      sb.push_back(model(1));
      mptr = 2;
      pend_id[1]++;
      rises = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         #1;
         if (i == 0) chk("zero_done_timing", 32'(if1.cli_done), 32'b0010);
         if (if1.rcp_req) rises++;
      end
      chk("zero_no_req", rises, 0);
      wait_idle();

      // reset during ISSUE with a stale ack held afterwards
      opA[0] = 8'hFF;
      opN[0] = 4'd4;
      hold_mask = 4'b0001;
      wait_req(1'b1, "grant_rstmid");
      repeat (3) @(negedge clock);
      ack_force = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstmid_req", 32'(if1.rcp_req), 0);
      chk("rstmid_ctrl", 32'({if1.busy, if1.grant_id, if1.cli_done, if1.cli_err}), 0);
      chk("rstmid_data", 32'({if1.rcp_A, if1.rcp_n_iter, if1.cli_P}), 0);
      hold_mask = '0;
      opA[0] = 8'h42;
      opN[0] = 4'd3;
      sb.push_back(model(0));
      pend_id[0]++;
      mptr = 1;
      @(negedge clock);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stale_ack_hold", 32'(if1.busy), 0);
      end
      ack_force = 1'b0;
      @(negedge clock);
      chk("first_idle_grant", 32'({if1.busy, if1.rcp_req}), 32'b11);
      wait_idle();

      // randomized batches
      for (int b = 0; b < 40; b++) begin
         bmask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin
            if (bmask[i]) begin
               opA[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
               opN[i] = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            end
         end
         issue_batch(bmask);
         wait_idle();
      end

      // watchdog path on the TIMEOUT=16 instance
      if2.cli_A = 32'h0000_2211;
      if2.cli_n_iter = 16'h0055;
      if2.cli_req = 4'b0011;
      tw = 0;
      while (!if2.rcp_req && tw < 20) begin
         @(negedge clock);
         tw++;
      end
      chk("to_grant", 32'(if2.rcp_req), 1);
      hi = 0;
      while (if2.rcp_req && hi < 100) begin
         hi++;
         @(negedge clock);
      end
      chk("to_req_cycles", hi, 16);
      chk("to_release_nodone", 32'(if2.cli_done), 0);
      @(negedge clock);
      chk("to_done", 32'(if2.cli_done), 32'b0001);
      chk("to_P", 32'(if2.cli_P), 0);
      chk("to_err", 32'(if2.cli_err), 1);
      if2.cli_req = 4'b0010;
      tw = 0;
      while (!if2.rcp_req && tw < 10) begin
         @(negedge clock);
         tw++;
      end
      chk("to_next_req", 32'(if2.rcp_req), 1);
      chk("to_next_grant", 32'(if2.grant_id), 1);
      if2.cli_req = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/reciprocal_arbiter.md
# reciprocal_arbiter

Round-robin arbiter and four-phase handshake sequencer that shares one `reciprocal` unit among `N_CLI` requesters. It drives the unit's `req/A/n_iter` inputs and consumes its `ack/P` outputs. It returns each result to the granted requester with a one-cycle done strobe. A watchdog aborts transactions the unit never acknowledges.

## Interface
- `N_CLI`, 4 — number of requesters (2..8).
- `TIMEOUT`, 4095 — max cycles to wait for `rcp_ack` rise in ISSUE.
- `clock` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `cli_req` in N_CLI — level request per client; held until its `cli_done` bit.
- `cli_A` in 8*N_CLI — operand, client i at bits [8i+7:8i].
- `cli_n_iter` in 4*N_CLI — iteration count, client i at [4i+3:4i].
- `cli_done` out N_CLI — one-cycle strobe to the served client.
- `cli_P` out 16 — result, valid while `cli_done` is nonzero.
- `cli_err` out 1 — qualifies `cli_done`: timeout or `n_iter`=0.
- `busy` out 1 — high in every state except IDLE.
- `grant_id` out clog2(N_CLI) — client currently owning the unit.
- `rcp_req` out 1 — request to the reciprocal unit.
- `rcp_A` out 8, `rcp_n_iter` out 4 — operands, registered, stable while `rcp_req`=1.
- `rcp_P` in 16, `rcp_ack` in 1 — result and acknowledge from the unit.

## Operation
- The FSM has five states: IDLE, ISSUE, RELEASE, DONE, ZDONE.
- **IDLE:** if any `cli_req` bit is set and `rcp_ack`=0, grant by round robin.
  - The search starts at pointer `ptr`: first set bit at `ptr`, `ptr+1`, ..., with wrap.
  - Latch `grant_id`, `rcp_A` and `rcp_n_iter` from the granted client.
  - If that client's `n_iter`=0, go to ZDONE. Otherwise set `rcp_req`=1, clear the watchdog counter, go to ISSUE.
  - If `rcp_ack`=1 in IDLE (stale acknowledge after reset), do not grant.
- **ISSUE:** hold `rcp_req`=1 with operands frozen, and count cycles.
  - If `rcp_ack` is sampled 1, capture `rcp_P` into the result register, set `rcp_req`=0, go to RELEASE.
  - If the counter reaches TIMEOUT-1 with no ack, set `rcp_req`=0, set the error flag, load result 0, go to RELEASE.
- **RELEASE:** wait for `rcp_ack`=0, then go to DONE. Exit is immediate if ack is already low.
- **DONE / ZDONE:** for one cycle, assert `cli_done[grant_id]`=1, drive `cli_P` from the result register, and drive `cli_err` from the error flag.
  - ZDONE always gives P=0 and err=1; the unit is not touched.
  - Then set `ptr` = (`grant_id`+1) mod `N_CLI`, clear the error flag, go to IDLE.
- Operands are sampled only at grant. Later changes on `cli_A`/`cli_n_iter` have no effect on the transaction in flight.
- A client that keeps `cli_req` high after its done re-enters arbitration at lowest priority.
- `cli_P` and `cli_err` are 0 whenever `cli_done`=0.

## Timing
- **Reset values:** state IDLE, `ptr`=0, `grant_id`=0, `rcp_req`=0, `rcp_A`=0, `rcp_n_iter`=0, `cli_done`=0, `cli_P`=0, `cli_err`=0, `busy`=0.
- **Reset mid-transaction:** `rcp_req` drops asynchronously and the transaction is lost with no done strobe. The IDLE stale-ack rule then holds off the next grant until the unit drops `ack`.
- `cli_req` sampled at edge k gives `rcp_req`=1 after edge k.
- `rcp_ack` sampled high at edge m gives `rcp_req`=0 after edge m. If ack falls before edge m+1, RELEASE exits at edge m+1 and `cli_done` is high for cycle m+2.
- **Minimum occupancy:** 4 cycles from grant to the next possible grant (IDLE, ISSUE, RELEASE, DONE), plus unit latency.
- **n_iter=0 path:** done appears 1 cycle after grant, and the next grant is possible 2 cycles after the previous one.
- **Timeout:** with no ack, `rcp_req` is high for exactly TIMEOUT cycles and done (err=1) follows 2 cycles later.
- `busy` and `grant_id` are registered and change on the same edge as the state.

## Test plan
- **Single client:** client 0 with A=8'hE1, n_iter=8, unit model acks after 20 cycles with P=16'h0123.
  - Expect `rcp_A`=8'hE1 and `rcp_n_iter`=8 while `rcp_req` is high.
  - Expect `cli_done`=4'b0001, `cli_P`=16'h0123, `cli_err`=0, 2 cycles after ack sampled (ack dropped immediately).
- **Round robin:** all four clients request continuously. Grants must be 0,1,2,3,0.
  - Then reset and request only clients 2 and 3 from `ptr`=0. Grants must be 2,3,2.
- **Zero iterations:** client 1 with n_iter=0.
  - Expect `cli_done`=4'b0010, P=0, err=1, one cycle after grant.
  - `rcp_req` must never rise.
- **Timeout:** TIMEOUT=16, the unit never acks.
  - Expect `rcp_req` high for exactly 16 cycles, then done with err=1 and P=0.
  - The next client is granted afterwards.
- **Reset mid-operation:** assert `rst` during ISSUE while the model holds ack=1 for 5 cycles after reset.
  - Expect all outputs at their reset values immediately.
  - No grant while ack=1; a grant on the first IDLE cycle with ack=0.
- **Operand stability:** change `cli_A` of the granted client during ISSUE.
  - `rcp_A` must keep the value latched at grant.
